// File: rtl/id_stage_hazard.sv
// Instruction decode stage: register file, ISA decode and ID/EX pipeline register with hazard control.
// Latency: one cycle from inst_f_if to the _2_ex outputs; register-file writes land on the next edge.
// Backpressure: ex_ready_f_ex low holds ID/EX and raises stall_2_if; load-use inserts one bubble; HALT freezes decode.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   inst_valid_f_if, inst_f_if, pc4_f_if      instruction from IF
//   ex_ready_f_ex, flush_f_ex                 EX acceptance and taken-branch kill
//   w_f_wb, addr_in_f_wb, write_data_f_wb     register-file write port from WB
//   stall_2_if, halted_2_if                   hold / frozen indications back to IF
//   valid_2_ex .. mem_write_2_ex              registered operands and control to EX
//
// Optional feature: define ID_WB_BYPASS_EN to forward a same-cycle WB write into the ID register read.
// Without it, a read returns the old register-file value and WB-to-ID dependencies need one cycle spacing.

module id_stage_hazard #(
    parameter int D_SIZE   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid_f_if,
    input  logic [31:0]       inst_f_if,
    input  logic [31:0]       pc4_f_if,
    input  logic              ex_ready_f_ex,
    input  logic              flush_f_ex,
    input  logic              w_f_wb,
    input  logic [ADDR_W-1:0] addr_in_f_wb,
    input  logic [D_SIZE-1:0] write_data_f_wb,
    output logic              stall_2_if,
    output logic              halted_2_if,
    output logic              valid_2_ex,
    output logic [31:0]       pc4_out_2_ex,
    output logic [5:0]        opcode_2_ex,
    output logic [D_SIZE-1:0] rs_val_2_ex,
    output logic [D_SIZE-1:0] rt_val_2_ex,
    output logic [ADDR_W-1:0] rd_addr_2_ex,
    output logic [D_SIZE-1:0] imm_2_ex,
    output logic              branch_2_ex,
    output logic              mem_read_2_ex,
    output logic              mem_to_reg_2_ex,
    output logic              mem_write_2_ex
);

    localparam logic [5:0] OP_LAST_ALU = 6'h0B;
    localparam logic [5:0] OP_LDW      = 6'h0C;
    localparam logic [5:0] OP_STW      = 6'h0D;
    localparam logic [5:0] OP_BZ       = 6'h0E;
    localparam logic [5:0] OP_BEQ      = 6'h0F;
    localparam logic [5:0] OP_JR       = 6'h10;
    localparam logic [5:0] OP_HALT     = 6'h11;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef struct packed {
        logic [31:0]       pc4;
        logic [5:0]        opcode;
        logic [D_SIZE-1:0] rs_val;
        logic [D_SIZE-1:0] rt_val;
        logic [ADDR_W-1:0] rd;
        logic [D_SIZE-1:0] imm;
        logic              branch;
        logic              mem_read;
        logic              mem_to_reg;
        logic              mem_write;
    } idex_t;

    logic [D_SIZE-1:0] r_regs [NUM_REGS];
    idex_t             r_idex;
    logic              r_valid;
    logic [0:0]        r_state;

    logic [5:0]        w_opcode;
    logic [ADDR_W-1:0] w_rs_addr;
    logic [ADDR_W-1:0] w_rt_addr;
    logic [ADDR_W-1:0] w_rd_field;
    logic [D_SIZE-1:0] w_imm_sx;
    logic [D_SIZE-1:0] w_rs_rd;
    logic [D_SIZE-1:0] w_rt_rd;
    idex_t             w_dec;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic              w_load_use;
    logic              w_stall;

    // Register fields are truncated to the implemented address width.
    assign w_opcode   = inst_f_if[31:26];
    assign w_rs_addr  = inst_f_if[21 +: ADDR_W];
    assign w_rt_addr  = inst_f_if[16 +: ADDR_W];
    assign w_rd_field = inst_f_if[11 +: ADDR_W];
    assign w_imm_sx   = {{(D_SIZE-16){inst_f_if[15]}}, inst_f_if[15:0]};

    // Register read ports; reg 0 is hardwired to zero regardless of forwarding.
    always_comb begin
        w_rs_rd = r_regs[w_rs_addr];
        w_rt_rd = r_regs[w_rt_addr];
`ifdef ID_WB_BYPASS_EN
        if (w_f_wb && (addr_in_f_wb == w_rs_addr)) w_rs_rd = write_data_f_wb;
        if (w_f_wb && (addr_in_f_wb == w_rt_addr)) w_rt_rd = write_data_f_wb;
`endif
        if (w_rs_addr == '0) w_rs_rd = '0;
        if (w_rt_addr == '0) w_rt_rd = '0;
    end

    // Decode. Opcode and PC+4 always pass through so EX can still identify HALT/illegal words.
    always_comb begin
        w_dec        = '0;
        w_dec.pc4    = pc4_f_if;
        w_dec.opcode = w_opcode;
        w_uses_rs    = 1'b0;
        w_uses_rt    = 1'b0;
        if (w_opcode <= OP_LAST_ALU) begin
            w_uses_rs        = 1'b1;
            w_dec.rs_val     = w_rs_rd;
            w_dec.mem_to_reg = 1'b1;
            if (!w_opcode[0]) begin
                // R-type: three-register form, no immediate
                w_uses_rt    = 1'b1;
                w_dec.rt_val = w_rt_rd;
                w_dec.rd     = w_rd_field;
            end else begin
                w_dec.rd  = w_rt_addr;
                w_dec.imm = w_imm_sx;
            end
        end else begin
            case (w_opcode)
                OP_LDW: begin
                    w_uses_rs        = 1'b1;
                    w_dec.rs_val     = w_rs_rd;
                    w_dec.rd         = w_rt_addr;
                    w_dec.imm        = w_imm_sx;
                    w_dec.mem_to_reg = 1'b1;
                    w_dec.mem_read   = 1'b1;
                end
                OP_STW: begin
                    w_uses_rs       = 1'b1;
                    w_uses_rt       = 1'b1;
                    w_dec.rs_val    = w_rs_rd;
                    w_dec.rt_val    = w_rt_rd;
                    w_dec.rd        = w_rt_addr;
                    w_dec.imm       = w_imm_sx;
                    w_dec.mem_write = 1'b1;
                end
                OP_BZ, OP_JR: begin
                    w_uses_rs    = 1'b1;
                    w_dec.rs_val = w_rs_rd;
                    w_dec.imm    = w_imm_sx;
                    w_dec.branch = 1'b1;
                end
                OP_BEQ: begin
                    w_uses_rs    = 1'b1;
                    w_uses_rt    = 1'b1;
                    w_dec.rs_val = w_rs_rd;
                    w_dec.rt_val = w_rt_rd;
                    w_dec.imm    = w_imm_sx;
                    w_dec.branch = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A load sitting in ID/EX cannot forward its data to the instruction now in ID.
    assign w_load_use = r_valid && r_idex.mem_read && (r_idex.rd != '0) && inst_valid_f_if &&
                        ((w_uses_rs && (r_idex.rd == w_rs_addr)) ||
                         (w_uses_rt && (r_idex.rd == w_rt_addr)));

    always_comb begin
        w_stall = 1'b0;
        if (r_state == ST_HALTED)  w_stall = 1'b1;
        else if (flush_f_ex)       w_stall = 1'b0;
        else if (!ex_ready_f_ex)   w_stall = 1'b1;
        else if (w_load_use)       w_stall = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_f_wb && (addr_in_f_wb != '0)) begin
            r_regs[addr_in_f_wb] <= write_data_f_wb;
        end
    end

    // ID/EX register and HALT state. Flush, load-use bubbles and the halted state all load an
    // all-zero entry so no stale control can reach EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idex  <= '0;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else if (r_state == ST_HALTED) begin
            r_idex  <= '0;
            r_valid <= 1'b0;
        end else if (flush_f_ex) begin
            r_idex  <= '0;
            r_valid <= 1'b0;
        end else if (!ex_ready_f_ex) begin
            r_idex  <= r_idex;
            r_valid <= r_valid;
        end else if (w_load_use) begin
            r_idex  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_idex  <= w_dec;
            r_valid <= inst_valid_f_if;
            if (inst_valid_f_if && (w_opcode == OP_HALT)) r_state <= ST_HALTED;
        end
    end

    assign stall_2_if      = w_stall;
    assign halted_2_if     = (r_state == ST_HALTED);
    assign valid_2_ex      = r_valid;
    assign pc4_out_2_ex    = r_idex.pc4;
    assign opcode_2_ex     = r_idex.opcode;
    assign rs_val_2_ex     = r_idex.rs_val;
    assign rt_val_2_ex     = r_idex.rt_val;
    assign rd_addr_2_ex    = r_idex.rd;
    assign imm_2_ex        = r_idex.imm;
    assign branch_2_ex     = r_idex.branch;
    assign mem_read_2_ex   = r_idex.mem_read;
    assign mem_to_reg_2_ex = r_idex.mem_to_reg;
    assign mem_write_2_ex  = r_idex.mem_write;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Self-checking bench for id_stage_hazard: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs compared one cycle after each applied instruction; stall compared combinationally.
// Backpressure: bench acts as IF and re-presents the same instruction while stall_2_if is high.

module tb_id_stage_hazard;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid_f_if;
    logic [31:0] inst_f_if;
    logic [31:0] pc4_f_if;
    logic        ex_ready_f_ex;
    logic        flush_f_ex;
    logic        w_f_wb;
    logic [4:0]  addr_in_f_wb;
    logic [31:0] write_data_f_wb;
    logic        stall_2_if;
    logic        halted_2_if;
    logic        valid_2_ex;
    logic [31:0] pc4_out_2_ex;
    logic [5:0]  opcode_2_ex;
    logic [31:0] rs_val_2_ex;
    logic [31:0] rt_val_2_ex;
    logic [4:0]  rd_addr_2_ex;
    logic [31:0] imm_2_ex;
    logic        branch_2_ex;
    logic        mem_read_2_ex;
    logic        mem_to_reg_2_ex;
    logic        mem_write_2_ex;

    id_stage_hazard dut (
        .clk(clk), .reset(reset),
        .inst_valid_f_if(inst_valid_f_if), .inst_f_if(inst_f_if), .pc4_f_if(pc4_f_if),
        .ex_ready_f_ex(ex_ready_f_ex), .flush_f_ex(flush_f_ex),
        .w_f_wb(w_f_wb), .addr_in_f_wb(addr_in_f_wb), .write_data_f_wb(write_data_f_wb),
        .stall_2_if(stall_2_if), .halted_2_if(halted_2_if), .valid_2_ex(valid_2_ex),
        .pc4_out_2_ex(pc4_out_2_ex), .opcode_2_ex(opcode_2_ex),
        .rs_val_2_ex(rs_val_2_ex), .rt_val_2_ex(rt_val_2_ex), .rd_addr_2_ex(rd_addr_2_ex),
        .imm_2_ex(imm_2_ex), .branch_2_ex(branch_2_ex), .mem_read_2_ex(mem_read_2_ex),
        .mem_to_reg_2_ex(mem_to_reg_2_ex), .mem_write_2_ex(mem_write_2_ex)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_valid, m_halted, m_dc;
    logic [31:0] m_pc4, m_rs, m_rt, m_imm;
    logic [5:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_br, m_mr, m_mtr, m_mw;
    logic        obs_stall;
    logic [31:0] next_pc4 = 32'h0;

    // Instruction classes: 0 R-type, 1 I-type ALU, 2 LDW, 3 STW, 4 BZ/JR, 5 BEQ, 6 HALT/other
    function automatic int op_class(input logic [5:0] op);
        if (op <= 6'h0B) return op[0] ? 1 : 0;
        case (op)
            6'h0C: return 2;
            6'h0D: return 3;
            6'h0E, 6'h10: return 4;
            6'h0F: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (w_f_wb && addr_in_f_wb == a) return write_data_f_wb;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_load_use();
        int c = op_class(inst_f_if[31:26]);
        logic rs_hit = (c <= 5) && (m_rd == inst_f_if[25:21]);
        logic rt_hit = (c == 0 || c == 3 || c == 5) && (m_rd == inst_f_if[20:16]);
        return m_valid && m_mr && (m_rd != 5'd0) && inst_valid_f_if && (rs_hit || rt_hit);
    endfunction

    function automatic logic model_stall();
        if (m_halted) return 1'b1;
        if (flush_f_ex) return 1'b0;
        if (!ex_ready_f_ex) return 1'b1;
        return model_load_use();
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 0; m_halted = 0; m_dc = 0;
        m_pc4 = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_op = 0; m_rd = 0;
        m_br = 0; m_mr = 0; m_mtr = 0; m_mw = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_dc = 1;
        m_br = 0; m_mr = 0; m_mtr = 0; m_mw = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic        lu = model_load_use();
        logic [5:0]  op = inst_f_if[31:26];
        int          c  = op_class(op);
        logic [31:0] sx = {{16{inst_f_if[15]}}, inst_f_if[15:0]};
        if (m_halted || flush_f_ex) begin
            model_bubble();
        end else if (!ex_ready_f_ex) begin
            // hold
        end else if (lu) begin
            model_bubble();
        end else begin
            m_pc4 = pc4_f_if;
            m_op  = op;
            m_rs  = (c <= 5) ? read_reg(inst_f_if[25:21]) : 32'h0;
            m_rt  = (c == 0 || c == 3 || c == 5) ? read_reg(inst_f_if[20:16]) : 32'h0;
            m_rd  = (c == 0) ? inst_f_if[15:11] : (c >= 1 && c <= 3) ? inst_f_if[20:16] : 5'd0;
            m_imm = (c == 0 || c == 6) ? 32'h0 : sx;
            m_mtr = (c <= 2);
            m_mr  = (c == 2);
            m_mw  = (c == 3);
            m_br  = (c == 4 || c == 5);
            m_valid = inst_valid_f_if;
            m_dc    = 0;
            if (inst_valid_f_if && op == 6'h11) m_halted = 1;
        end
        if (w_f_wb && addr_in_f_wb != 5'd0) m_regs[addr_in_f_wb] = write_data_f_wb;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("valid",      valid_2_ex,      m_valid);
        chk("halted",     halted_2_if,     m_halted);
        chk("branch",     branch_2_ex,     m_br);
        chk("mem_read",   mem_read_2_ex,   m_mr);
        chk("mem_to_reg", mem_to_reg_2_ex, m_mtr);
        chk("mem_write",  mem_write_2_ex,  m_mw);
        if (!m_dc) begin
            chk("pc4",    pc4_out_2_ex, m_pc4);
            chk("opcode", opcode_2_ex,  m_op);
            chk("rs_val", rs_val_2_ex,  m_rs);
            chk("rt_val", rt_val_2_ex,  m_rt);
            chk("rd",     rd_addr_2_ex, m_rd);
            chk("imm",    imm_2_ex,     m_imm);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd);
        next_pc4        = next_pc4 + 32'd4;
        inst_valid_f_if = v;
        inst_f_if       = ins;
        pc4_f_if        = next_pc4;
        ex_ready_f_ex   = rdy;
        flush_f_ex      = fl;
        w_f_wb          = w;
        addr_in_f_wb    = wa;
        write_data_f_wb = wd;
    endtask

    // Called at posedge+1 with inputs applied: checks stall, clocks, checks registered outputs.
    task automatic cycle();
        #1;
        obs_stall = stall_2_if;
        chk("stall", obs_stall, model_stall());
        model_edge();
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk_outs();
        chk("reset_stall", stall_2_if, model_stall());
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] r_inst(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] lo);
        return {op, rs, rt, lo};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_byp;
        logic [31:0] ins;
        reset = 1'b1;
        drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        #1;
        do_reset();

        // ADDI r1, r0, 0xFFF0
        drive(1, r_inst(6'h01, 5'd0, 5'd1, 16'hFFF0), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("addi_rd",  rd_addr_2_ex,    32'd1);
        chk("addi_imm", imm_2_ex,        32'hFFFF_FFF0);
        chk("addi_vld", valid_2_ex,      1'b1);
        chk("addi_mtr", mem_to_reg_2_ex, 1'b1);

        // ADD r4, r3, r3 while WB writes r3 = 0x55
`ifdef ID_WB_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h0;
`endif
        drive(1, r_inst(6'h00, 5'd3, 5'd3, {5'd4, 11'd0}), 1, 0, 1, 5'd3, 32'h55);
        cycle();
        chk("byp_rs", rs_val_2_ex, exp_byp);
        chk("byp_rt", rt_val_2_ex, exp_byp);
        drive(1, r_inst(6'h00, 5'd3, 5'd3, {5'd4, 11'd0}), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("rf_rs", rs_val_2_ex, 32'h55);

        // LDW r2 then ADD r5, r2, r1: one stall cycle, one bubble, then ADD
        drive(1, r_inst(6'h0C, 5'd0, 5'd2, 16'h0010), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("ldw_mr", mem_read_2_ex, 1'b1);
        drive(1, r_inst(6'h00, 5'd2, 5'd1, {5'd5, 11'd0}), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("lu_stall",  obs_stall,  1'b1);
        chk("lu_bubble", valid_2_ex, 1'b0);
        next_pc4 = next_pc4 - 32'd4;
        drive(1, r_inst(6'h00, 5'd2, 5'd1, {5'd5, 11'd0}), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("lu_release", obs_stall,    1'b0);
        chk("lu_add_vld", valid_2_ex,   1'b1);
        chk("lu_add_rd",  rd_addr_2_ex, 32'd5);

        // EX not ready for three cycles: ID/EX holds the ADD
        for (int i = 0; i < 3; i++) begin
            drive(1, r_inst(6'h02, 5'd1, 5'd1, {5'd7, 11'd0}), 0, 0, 0, 5'd0, 32'h0);
            cycle();
            chk("hold_stall", obs_stall,    1'b1);
            chk("hold_rd",    rd_addr_2_ex, 32'd5);
            chk("hold_op",    opcode_2_ex,  32'h0);
            chk("hold_vld",   valid_2_ex,   1'b1);
        end

        // BEQ in ID while EX flushes
        drive(1, r_inst(6'h0F, 5'd1, 5'd2, 16'h0008), 1, 1, 0, 5'd0, 32'h0);
        cycle();
        chk("flush_stall",  obs_stall,   1'b0);
        chk("flush_vld",    valid_2_ex,  1'b0);
        chk("flush_branch", branch_2_ex, 1'b0);

        // Randomized traffic; IF re-presents the instruction while stalled
        ins = 32'h0;
        obs_stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!obs_stall)
                ins = r_inst(6'($urandom_range(0, 16)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 16'($urandom));
            drive(($urandom % 10) < 8, ins, ($urandom % 100) < 85, ($urandom % 100) < 8,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end

        // Reset while a load-use stall is pending
        drive(1, r_inst(6'h0C, 5'd0, 5'd6, 16'h0004), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        drive(1, r_inst(6'h01, 5'd6, 5'd7, 16'h0001), 1, 0, 0, 5'd0, 32'h0);
        #2;
        chk("mid_stall", stall_2_if, 1'b1);
        do_reset();
        chk("post_rst_vld", valid_2_ex, 1'b0);

        // HALT issues, then decode stays frozen
        drive(1, {6'h11, 26'h0}, 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("halt_flag", halted_2_if, 1'b1);
        chk("halt_vld",  valid_2_ex,  1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1, r_inst(6'($urandom_range(0, 16)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 16'($urandom)),
                  1'($urandom), 1'($urandom), 1, 5'd9, $urandom);
            cycle();
            chk("halted_vld",   valid_2_ex, 1'b0);
            chk("halted_stall", obs_stall,  1'b1);
        end

        // Reset leaves HALTED and the stage runs again
        do_reset();
        chk("rst_halted", halted_2_if, 1'b0);
        chk("rst_rs",     rs_val_2_ex, 32'h0);
        drive(1, r_inst(6'h01, 5'd0, 5'd1, 16'h0123), 1, 0, 0, 5'd0, 32'h0);
        cycle();
        chk("rerun_vld", valid_2_ex, 1'b1);
        chk("rerun_imm", imm_2_ex,   32'h0000_0123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
